lifo_fifo_buffer: RTL and testbench
===================================

Name: lifo_fifo_buffer

Overview:
- Parametrised storage buffer with a run-time selectable discipline: LIFO (stack) or FIFO (queue).
- Adds registered read data with a valid strobe, push/pop pass-through, independent threshold flags, and sticky overflow/underflow error flags.
- Used wherever a local stack or queue is needed and the ordering is chosen by configuration rather than at build time.

Parameters:
- p_width, 8, data word width in bits
- p_depth, 16, number of entries; any value >= 2, power of two not required
- p_awidth, $clog2(p_depth), pointer width
- p_af_thresh, 4, almost_full asserted when count >= p_depth - p_af_thresh
- p_ae_thresh, 4, almost_empty asserted when count <= p_ae_thresh

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mode_sel  in  1  requested mode: 0 = LIFO, 1 = FIFO
- mode_load  in  1  strobe to load mode_sel into mode
- mode  out  1  current mode
- wr_req  in  1  push/enqueue request
- wr_data  in  p_width  write data
- full  out  1  count == p_depth
- almost_full  out  1  threshold flag
- overflow  out  1  sticky: a write request was rejected
- rd_req  in  1  pop/dequeue request
- rd_data  out  p_width  registered read data
- rd_valid  out  1  one-cycle strobe; rd_data is valid
- empty  out  1  count == 0
- almost_empty  out  1  threshold flag
- underflow  out  1  sticky: a read request was rejected
- err_clear  in  1  clears overflow and underflow
- data_count  out  p_awidth+1  number of stored entries

Behaviour:
- Reset (synchronous, active-high; clock is clock):
  - head, tail, count, rd_data, rd_valid, overflow, underflow and mode all clear to 0, so mode resets to LIFO.
  - Memory contents are not reset.
- Storage and pointers:
  - Storage is a circular array.
  - tail is the next write slot; head is the oldest entry.
  - Pointers wrap explicitly: p_depth-1 + 1 -> 0, and 0 - 1 -> p_depth-1. This must work for non-power-of-two depths.
- Accept rules:
  - rd_en = rd_req & ~empty.
  - wr_en = wr_req & (~full | rd_en), so a write while full is accepted only together with an accepted read.
- LIFO mode:
  - Write only: mem[tail] <= wr_data; tail++; count++.
  - Read only: rd_data <= mem[tail-1]; tail--; count--.
  - Write and read together: pass-through. rd_data <= wr_data; memory, tail and count unchanged.
- FIFO mode:
  - Write only: mem[tail] <= wr_data; tail++; count++.
  - Read only: rd_data <= mem[head]; head++; count--.
  - Write and read together: both pointers advance; count unchanged.
  - When full, tail == head. The read captures the old mem[head] (read-before-write), and the new data lands in the freed slot.
- Read latency is 1 cycle:
  - rd_valid = 1 in the cycle after rd_en; otherwise 0.
  - rd_data holds its last value while rd_valid = 0.
- Flags:
  - full, almost_full, empty, almost_empty and data_count are combinational from the registered count.
  - They reflect an operation in the cycle after it is accepted.
- Errors:
  - overflow sets on wr_req & ~wr_en.
  - underflow sets on rd_req & empty.
  - Both hold until err_clear or reset. If a set and err_clear occur in the same cycle, set wins.
- Mode change:
  - mode_load takes effect only when empty = 1 and wr_req = rd_req = 0 in that cycle.
  - Otherwise mode_load is ignored and mode is unchanged.
  - When a load is accepted, head and tail both return to 0.
- Reset mid-operation: reset overrides all requests that cycle, and no write is committed.
- data_count never exceeds p_depth and never goes below 0.

Test Plan:
- LIFO, p_depth=4: push 0x11,0x22,0x33,0x44 -> full=1, data_count=4, almost_full=1. A 5th push -> overflow=1, count stays 4. Four pops -> rd_data 0x44,0x33,0x22,0x11, each with rd_valid one cycle later; then empty=1.
- FIFO: load mode=1 while empty. Push 0xA0..0xA5 into p_depth=4, reading each 0xA? as it arrives to force pointer wrap -> reads return in write order, and count never exceeds 4.
- Simultaneous push+pop: LIFO holding 2 entries, wr 0x5A with rd -> rd_data=0x5A next cycle, count stays 2. FIFO full (count 4), wr 0x77 with rd -> rd_data = oldest entry, count=4, 0x77 emerges last.
- Error flags: rd_req when empty -> underflow=1, rd_valid stays 0. err_clear alone -> 0. err_clear with rd_req on empty -> underflow stays 1.
- Mode guard: mode_load with count=1 -> mode unchanged. Pop to empty, then mode_load with mode_sel=1 -> mode=1 next cycle.
- Reset mid-stream: after 3 pushes, assert reset with wr_req=1 -> count=0, empty=1, mode=0, rd_valid=0, error flags 0.

Source files
------------

// File: rtl/lifo_fifo_buffer.sv
// Circular-array storage buffer whose ordering (stack or queue) is chosen at run time.
// Registered read data with a one-cycle valid strobe, threshold flags and sticky error flags.
module lifo_fifo_buffer #(
  parameter int p_width     = 8,
  parameter int p_depth     = 16,
  parameter int p_awidth    = $clog2(p_depth),
  parameter int p_af_thresh = 4,
  parameter int p_ae_thresh = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode_sel,
  input  logic                mode_load,
  output logic                mode,
  input  logic                wr_req,
  input  logic [p_width-1:0]  wr_data,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  input  logic                rd_req,
  output logic [p_width-1:0]  rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                almost_empty,
  output logic                underflow,
  input  logic                err_clear,
  output logic [p_awidth:0]   data_count
);

  localparam int c_cw = p_awidth + 1;
  localparam int c_pw = p_awidth;
  localparam logic [p_awidth:0]   c_depth    = c_cw'(p_depth);
  localparam logic [p_awidth:0]   c_af_level = c_cw'(p_depth - p_af_thresh);
  localparam logic [p_awidth:0]   c_ae_level = c_cw'(p_ae_thresh);
  localparam logic [p_awidth-1:0] c_last     = c_pw'(p_depth - 1);

  // Explicit wrap so depths that are not a power of two stay inside the array.
  function automatic logic [p_awidth-1:0] ptr_inc(input logic [p_awidth-1:0] p);
    if (p == c_last) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [p_awidth-1:0] ptr_dec(input logic [p_awidth-1:0] p);
    if (p == '0) return c_last;
    return p - 1'b1;
  endfunction

  logic [p_width-1:0]  mem_q [p_depth];

  logic [p_awidth-1:0] head_q, head_d;
  logic [p_awidth-1:0] tail_q, tail_d;
  logic [p_awidth:0]   count_q, count_d;
  logic [p_width-1:0]  rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                mode_q, mode_d;

  logic                full_w, empty_w;
  logic                rd_en, wr_en, load_ok, mem_we;
  logic [p_awidth-1:0] tail_dec;

  assign full_w   = (count_q == c_depth);
  assign empty_w  = (count_q == '0);
  assign tail_dec = ptr_dec(tail_q);

  always_comb begin
    rd_en       = rd_req & ~empty_w;
    wr_en       = wr_req & (~full_w | rd_en);
    load_ok     = mode_load & empty_w & ~wr_req & ~rd_req;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_en;
    mode_d      = mode_q;
    mem_we      = 1'b0;

    if (!mode_q) begin
      unique case ({wr_en, rd_en})
        // Stack push+pop of the same word never touches storage.
        2'b11: rd_data_d = wr_data;
        2'b10: begin
          mem_we  = 1'b1;
          tail_d  = ptr_inc(tail_q);
          count_d = count_q + 1'b1;
        end
        2'b01: begin
          rd_data_d = mem_q[tail_dec];
          tail_d    = tail_dec;
          count_d   = count_q - 1'b1;
        end
        default: ;
      endcase
    end else begin
      // When full, head == tail: the read samples the old word before the write replaces it.
      if (wr_en) begin
        mem_we = 1'b1;
        tail_d = ptr_inc(tail_q);
      end
      if (rd_en) begin
        rd_data_d = mem_q[head_q];
        head_d    = ptr_inc(head_q);
      end
      if (wr_en && !rd_en) count_d = count_q + 1'b1;
      else if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end

    if (load_ok) begin
      mode_d = mode_sel;
      head_d = '0;
      tail_d = '0;
    end

    overflow_d  = (wr_req & ~wr_en) | (overflow_q & ~err_clear);
    underflow_d = (rd_req & empty_w) | (underflow_q & ~err_clear);

    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mode_q      <= mode_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[tail_q] <= wr_data;
  end

  assign mode         = mode_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= c_af_level);
  assign almost_empty = (count_q <= c_ae_level);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign data_count   = count_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Bench for lifo_fifo_buffer: hand-written vector table plus a queue-based model whose
// read results feed a scoreboard, followed by a constrained random mixed-traffic run.
module tb_lifo_fifo_buffer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset, mode_sel, mode_load, mode;
  logic         wr_req, full, almost_full, overflow;
  logic [W-1:0] wr_data, rd_data;
  logic         rd_req, rd_valid, empty, almost_empty, underflow, err_clear;
  logic [2:0]   data_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst, wr;
    logic [7:0] wd;
    bit         rd, ld, sel, clr;
    int         cnt;
    bit         mode, ov, un, vld;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         mmode, mov, mun;

  lifo_fifo_buffer #(
    .p_width(W), .p_depth(D), .p_af_thresh(1), .p_ae_thresh(1)
  ) dut (
    .clock(clock), .reset(reset), .mode_sel(mode_sel), .mode_load(mode_load), .mode(mode),
    .wr_req(wr_req), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .overflow(overflow), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .almost_empty(almost_empty), .underflow(underflow),
    .err_clear(err_clear), .data_count(data_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit wr, input logic [7:0] wd, input bit rd,
                     input bit ld, input bit sel, input bit clr, input int cnt,
                     input bit md, input bit ov, input bit un, input bit vld);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wd = wd; v.rd = rd; v.ld = ld; v.sel = sel; v.clr = clr;
    v.cnt = cnt; v.mode = md; v.ov = ov; v.un = un; v.vld = vld;
    vecs.push_back(v);
  endtask

  // Drive one cycle, advance the model, then sample after the edge and run the scoreboard.
  task automatic step(input bit rst, input bit wr, input logic [7:0] wd, input bit rd,
                      input bit ld, input bit sel, input bit clr, input int idx);
    bit         m_empty, m_full, rd_en, wr_en;
    logic [7:0] e;
    @(negedge clock);
    reset = rst; wr_req = wr; wr_data = wd; rd_req = rd;
    mode_load = ld; mode_sel = sel; err_clear = clr;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == D);
    if (rst) begin
      mq.delete(); mmode = 1'b0; mov = 1'b0; mun = 1'b0;
    end else begin
      rd_en = rd && !m_empty;
      wr_en = wr && (!m_full || rd_en);
      mov = (wr && !wr_en) || (mov && !clr);
      mun = (rd && m_empty) || (mun && !clr);
      if (rd_en) begin
        if (!mmode) begin
          if (wr_en) e = wd;
          else e = mq.pop_back();
        end else begin
          e = mq.pop_front();
          if (wr_en) mq.push_back(wd);
        end
        sb.push_back(e);
      end else if (wr_en) begin
        mq.push_back(wd);
      end
      if (ld && m_empty && !wr && !rd) mmode = sel;
    end
    @(posedge clock);
    #1;
    if (rd_valid) begin
      if (sb.size() == 0) chk("unexpected_rd_valid", idx, 1, 0);
      else begin
        e = sb.pop_front();
        chk("rd_data", idx, int'(rd_data), int'(e));
      end
    end else if (sb.size() != 0) begin
      chk("missing_rd_valid", idx, 0, 1);
      void'(sb.pop_front());
    end
    chk("model_count", idx, int'(data_count), mq.size());
    chk("model_mode", idx, int'(mode), int'(mmode));
    chk("model_overflow", idx, int'(overflow), int'(mov));
    chk("model_underflow", idx, int'(underflow), int'(mun));
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0;
    mode_load = 1'b0; mode_sel = 1'b0; err_clear = 1'b0;
    mmode = 1'b0; mov = 1'b0; mun = 1'b0;

    //  rst wr  wd     rd ld sel clr  cnt mode ov un vld
    add(1, 0, 8'h00, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 1, 8'h11, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 1, 8'h22, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    add(0, 1, 8'h33, 0, 0, 0, 0,   3, 0, 0, 0, 0);
    add(0, 1, 8'h44, 0, 0, 0, 0,   4, 0, 0, 0, 0);
    add(0, 1, 8'h55, 0, 0, 0, 0,   4, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0,   3, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   2, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 0, 1, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 1,   0, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 1, 0,   1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 0,   0, 1, 0, 0, 0);
    add(0, 1, 8'hA0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 1, 8'hA1, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add(0, 1, 8'hA2, 1, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 1, 8'hA3, 1, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 1, 8'hA4, 1, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 1, 8'hA5, 1, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    add(0, 1, 8'hB1, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 1, 8'hB2, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add(0, 1, 8'hB3, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    add(0, 1, 8'hB4, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 1, 8'h77, 1, 0, 0, 0,   4, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   3, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   2, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   1, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    add(0, 1, 8'hC1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(0, 1, 8'hC2, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    add(0, 1, 8'h5A, 1, 0, 0, 0,   2, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   1, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 0,   0, 1, 0, 0, 0);
    add(0, 1, 8'hD1, 0, 1, 0, 0,   1, 1, 0, 0, 0);
    add(0, 1, 8'hD2, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add(0, 1, 8'hD3, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    add(0, 1, 8'hD4, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 1, 8'hD5, 0, 0, 0, 0,   4, 1, 1, 0, 0);
    add(1, 1, 8'hE0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0,   0, 0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1,   0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd,
           vecs[i].ld, vecs[i].sel, vecs[i].clr, i);
      chk("count", i, int'(data_count), vecs[i].cnt);
      chk("mode", i, int'(mode), int'(vecs[i].mode));
      chk("overflow", i, int'(overflow), int'(vecs[i].ov));
      chk("underflow", i, int'(underflow), int'(vecs[i].un));
      chk("rd_valid", i, int'(rd_valid), int'(vecs[i].vld));
      chk("full", i, int'(full), int'(vecs[i].cnt == D));
      chk("empty", i, int'(empty), int'(vecs[i].cnt == 0));
      chk("almost_full", i, int'(almost_full), int'(vecs[i].cnt >= D - 1));
      chk("almost_empty", i, int'(almost_empty), int'(vecs[i].cnt <= 1));
    end

    // Mixed random traffic in both modes, checked only against the model and scoreboard.
    for (int n = 0; n < 400; n++) begin
      bit         r_wr, r_rd, r_ld, r_clr, r_rst;
      logic [7:0] r_d;
      r_wr  = ($urandom_range(0, 99) < 55);
      r_rd  = ($urandom_range(0, 99) < 45);
      r_ld  = ($urandom_range(0, 9) == 0);
      r_clr = ($urandom_range(0, 15) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      r_d   = 8'($urandom);
      if (r_ld) begin
        r_wr = 1'b0;
        r_rd = ($urandom_range(0, 3) == 0);
      end
      if (n % 60 == 59) begin
        r_wr = 1'b0; r_rd = 1'b0; r_ld = 1'b0;
      end
      step(r_rst, r_wr, r_d, r_rd, r_ld, 1'($urandom), r_clr, 1000 + n);
      chk("rnd_full", 1000 + n, int'(full), int'(mq.size() == D));
      chk("rnd_empty", 1000 + n, int'(empty), int'(mq.size() == 0));
    end

    step(0, 0, 8'h00, 0, 0, 0, 0, 2000);
    chk("scoreboard_drained", 2000, sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
